// File: rtl/vram_loader_pkg.sv
// Shared opcodes, FSM state encoding and address-width helper for the VRAM loader.
package vram_loader_pkg;

    localparam logic [7:0] OP_WRITE = 8'h53;
    localparam logic [7:0] OP_FILL  = 8'h46;

    typedef enum logic [3:0] {
        S_IDLE,
        S_A2,
        S_A1,
        S_A0,
        S_L1,
        S_L0,
        S_DATA,
        S_FILL_ARG,
        S_FILL
    } state_t;

    function automatic int unsigned vram_aw(input int unsigned w, input int unsigned h);
        return $clog2(w * h);
    endfunction

endpackage

// File: rtl/vram_loader_pixel_unpacker.sv
// Serialises bytes MSB first into one pixel per cycle, with a one-byte holding buffer.
module pixel_unpacker (
    input  logic       CLK,
    input  logic       RST_,
    input  logic       LOAD,
    input  logic [7:0] BYTE,
    output logic       PIX,
    output logic       PIX_VALID,
    output logic       FULL,
    output logic       LAST
);
    logic [7:0] sr;
    logic [7:0] hold;
    logic [2:0] cnt;
    logic       active;
    logic       hold_valid;

    // An idle unpacker emits the MSB of an incoming byte in the same cycle it is loaded.
    assign PIX       = active ? sr[7] : BYTE[7];
    assign PIX_VALID = active || LOAD;
    assign LAST      = active && (cnt == 3'd7);
    assign FULL      = active && hold_valid && !LAST;

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            sr         <= '0;
            hold       <= '0;
            cnt        <= '0;
            active     <= 1'b0;
            hold_valid <= 1'b0;
        end else if (!active) begin
            if (LOAD) begin
                sr     <= {BYTE[6:0], 1'b0};
                cnt    <= 3'd1;
                active <= 1'b1;
            end
        end else if (LAST) begin
            // Last bit goes out now; refill from the buffer or the incoming byte with no gap.
            if (hold_valid) begin
                sr         <= hold;
                cnt        <= 3'd0;
                hold_valid <= LOAD;
                if (LOAD) begin
                    hold <= BYTE;
                end
            end else if (LOAD) begin
                sr  <= BYTE;
                cnt <= 3'd0;
            end else begin
                active <= 1'b0;
            end
        end else begin
            sr  <= {sr[6:0], 1'b0};
            cnt <= cnt + 3'd1;
            if (LOAD && !hold_valid) begin
                hold       <= BYTE;
                hold_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_loader.sv
// UART byte-stream parser that turns write and fill commands into 1-bpp VRAM pixel writes.
module vram_loader
    import vram_loader_pkg::*;
#(
    parameter int unsigned W = 640,
    parameter int unsigned H = 480
) (
    input  logic                     CLK,
    input  logic                     RST_,
    input  logic [7:0]               RX_DATA,
    input  logic                     RX_VALID,
    output logic                     WE,
    output logic [vram_aw(W, H)-1:0] WADDR,
    output logic                     WDATA,
    output logic                     BUSY,
    output logic                     OVF
);
    localparam int unsigned DEPTH = W * H;
    localparam int unsigned AW    = vram_aw(W, H);
    localparam int unsigned FW    = AW + 1;

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] start_c;
    logic [AW-1:0] pa;
    logic [7:0]    len_hi;
    logic [15:0]   rx_left;
    logic [15:0]   pend;
    logic [FW-1:0] fc;
    logic          load_c;
    logic          drop_c;
    logic          arg_c;
    logic          pix;
    logic          pix_valid;
    logic          up_full;
    logic          up_last;

    pixel_unpacker u_unpacker (
        .CLK       (CLK),
        .RST_      (RST_),
        .LOAD      (load_c),
        .BYTE      (RX_DATA),
        .PIX       (pix),
        .PIX_VALID (pix_valid),
        .FULL      (up_full),
        .LAST      (up_last)
    );

    // Out-of-range start addresses fall back to pixel 0.
    assign start_c = ({1'b0, addr_q} >= FW'(DEPTH)) ? '0 : addr_q;
    assign load_c  = (state == S_DATA) && RX_VALID && (rx_left != 16'd0) && !up_full;
    assign drop_c  = RX_VALID && (((state == S_DATA) && (rx_left != 16'd0) && up_full)
                                  || (state == S_FILL));
    assign arg_c   = (state == S_FILL_ARG) && RX_VALID;

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (RX_VALID && (RX_DATA == OP_WRITE)) begin
                    next_state = S_A2;
                end else if (RX_VALID && (RX_DATA == OP_FILL)) begin
                    next_state = S_FILL_ARG;
                end
            end
            S_A2:       if (RX_VALID) next_state = S_A1;
            S_A1:       if (RX_VALID) next_state = S_A0;
            S_A0:       if (RX_VALID) next_state = S_L1;
            S_L1:       if (RX_VALID) next_state = S_L0;
            S_L0: begin
                if (RX_VALID) begin
                    next_state = ({len_hi, RX_DATA} != 16'd0) ? S_DATA : S_IDLE;
                end
            end
            // pend counts bytes whose eighth pixel has not yet been written.
            S_DATA:     if (pend == 16'd0) next_state = S_IDLE;
            S_FILL_ARG: if (RX_VALID) next_state = S_FILL;
            S_FILL:     if (fc == FW'(DEPTH)) next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            addr_q  <= '0;
            len_hi  <= '0;
            rx_left <= '0;
            pend    <= '0;
            pa      <= '0;
            fc      <= '0;
            WE      <= 1'b0;
            WADDR   <= '0;
            WDATA   <= 1'b0;
            BUSY    <= 1'b0;
            OVF     <= 1'b0;
        end else begin
            WE   <= 1'b0;
            BUSY <= (next_state != S_IDLE);
            if (drop_c) begin
                OVF <= 1'b1;
            end
            if (RX_VALID) begin
                case (state)
                    S_A2, S_A1, S_A0: addr_q <= AW'({addr_q, RX_DATA});
                    S_L1:             len_hi <= RX_DATA;
                    S_L0: begin
                        rx_left <= {len_hi, RX_DATA};
                        pend    <= {len_hi, RX_DATA};
                        pa      <= start_c;
                    end
                    default: ;
                endcase
            end
            if (load_c) begin
                rx_left <= rx_left - 16'd1;
            end
            if (up_last) begin
                pend <= pend - 16'd1;
            end
            // Write port: fill has priority; the unpacker is idle outside DATA.
            if (arg_c) begin
                WE    <= 1'b1;
                WADDR <= '0;
                WDATA <= RX_DATA[0];
                fc    <= FW'(1);
            end else if ((state == S_FILL) && (fc != FW'(DEPTH))) begin
                WE    <= 1'b1;
                WADDR <= fc[AW-1:0];
                fc    <= fc + FW'(1);
            end else if (pix_valid) begin
                WE    <= 1'b1;
                WADDR <= pa;
                WDATA <= pix;
                pa    <= (pa == AW'(DEPTH - 1)) ? '0 : pa + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vram_loader.sv
// Directed bench for vram_loader on a 10x5 frame so fills stay short.
module tb_vram_loader;
    localparam int unsigned TW    = 10;
    localparam int unsigned TH    = 5;
    localparam int unsigned DEPTH = TW * TH;
    localparam int unsigned AW    = $clog2(TW * TH);

    logic          CLK;
    logic          RST_;
    logic [7:0]    RX_DATA;
    logic          RX_VALID;
    logic          WE;
    logic [AW-1:0] WADDR;
    logic          WDATA;
    logic          BUSY;
    logic          OVF;

    int n_vec  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int rx_cyc = 0;

    logic [AW-1:0] cap_addr[$];
    logic          cap_data[$];
    int            cap_cyc[$];
    logic [AW-1:0] exp_addr[$];
    logic          exp_data[$];

    vram_loader #(.W(TW), .H(TH)) dut (
        .CLK      (CLK),
        .RST_     (RST_),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .WE       (WE),
        .WADDR    (WADDR),
        .WDATA    (WDATA),
        .BUSY     (BUSY),
        .OVF      (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Record every pixel write and the cycle of the latest received byte.
    always @(negedge CLK) begin
        if (RX_VALID) rx_cyc = cyc;
        if (RST_ && WE) begin
            cap_addr.push_back(WADDR);
            cap_data.push_back(WDATA);
            cap_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        tick();
        RX_VALID = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] a2, input logic [7:0] a1, input logic [7:0] a0,
                            input logic [7:0] l1, input logic [7:0] l0);
        send(8'h53);
        send(a2);
        send(a1);
        send(a0);
        send(l1);
        send(l0);
    endtask

    task automatic clear();
        cap_addr.delete();
        cap_data.delete();
        cap_cyc.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic push_byte(input logic [7:0] b, inout int a);
        for (int i = 7; i >= 0; i--) begin
            exp_addr.push_back(AW'(a));
            exp_data.push_back(b[i]);
            a = (a == int'(DEPTH) - 1) ? 0 : a + 1;
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int g = 0; g < 200 && BUSY === 1'b1; g++) tick();
        chk({tag, " idle"}, 32'(BUSY), 32'(0));
    endtask

    task automatic chk_stream(input string tag, input int first);
        chk({tag, " count"}, 32'(cap_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i < cap_addr.size()) begin
                chk($sformatf("%s[%0d] addr", tag, i), 32'(cap_addr[i]), 32'(exp_addr[i]));
                chk($sformatf("%s[%0d] data", tag, i), 32'(cap_data[i]), 32'(exp_data[i]));
                chk($sformatf("%s[%0d] cyc", tag, i), 32'(cap_cyc[i]), 32'(first + i));
            end
        end
        clear();
    endtask

    initial begin
        int a;
        int n;
        RST_     = 1'b0;
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
        repeat (2) tick();
        chk("reset WE", 32'(WE), 32'(0));
        chk("reset WADDR", 32'(WADDR), 32'(0));
        chk("reset WDATA", 32'(WDATA), 32'(0));
        chk("reset BUSY", 32'(BUSY), 32'(0));
        chk("reset OVF", 32'(OVF), 32'(0));
        RST_ = 1'b1;
        tick();

        // Single byte A5 at address 0.
        clear();
        send(8'h53);
        chk("hdr BUSY", 32'(BUSY), 32'(1));
        send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'h01);
        send(8'hA5);
        n = rx_cyc;
        chk("a5 first WE", 32'(WE), 32'(1));
        repeat (7) tick();
        chk("a5 BUSY last px", 32'(BUSY), 32'(1));
        tick();
        chk("a5 BUSY drop", 32'(BUSY), 32'(0));
        chk("a5 OVF", 32'(OVF), 32'(0));
        a = 0;
        push_byte(8'hA5, a);
        chk_stream("a5", n + 1);

        // Start at the last pixel, wrap to 0, second byte through the holding buffer.
        send_hdr(8'h00, 8'h00, 8'h31, 8'h00, 8'h02);
        send(8'hFF);
        n = rx_cyc;
        send(8'h00);
        wait_idle("wrap");
        a = int'(DEPTH) - 1;
        push_byte(8'hFF, a);
        push_byte(8'h00, a);
        chk_stream("wrap", n + 1);
        chk("wrap OVF", 32'(OVF), 32'(0));

        // Start address beyond the frame restarts at 0.
        send_hdr(8'h00, 8'h00, 8'h3A, 8'h00, 8'h01);
        send(8'h80);
        n = rx_cyc;
        wait_idle("oob");
        a = 0;
        push_byte(8'h80, a);
        chk_stream("oob", n + 1);

        // Zero length: back to IDLE right after L0, no writes.
        send_hdr(8'h00, 8'h00, 8'h10, 8'h00, 8'h00);
        chk("len0 BUSY", 32'(BUSY), 32'(0));
        repeat (10) tick();
        chk("len0 writes", 32'(cap_addr.size()), 32'(0));

        // Fill with 1, plus a stray byte mid-fill.
        send(8'h46);
        send(8'h01);
        n = rx_cyc;
        repeat (4) tick();
        chk("fill OVF before", 32'(OVF), 32'(0));
        send(8'h77);
        chk("fill OVF after", 32'(OVF), 32'(1));
        for (int g = 0; g < 200 && BUSY === 1'b1; g++) tick();
        chk("fill BUSY drop cycle", 32'(cyc), 32'(n + int'(DEPTH) + 1));
        for (int i = 0; i < int'(DEPTH); i++) begin
            exp_addr.push_back(AW'(i));
            exp_data.push_back(1'b1);
        end
        chk_stream("fill", n + 1);

        // Asynchronous reset during the fourth pixel of a byte.
        send_hdr(8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
        send(8'hFF);
        repeat (3) tick();
        chk("mid WE before reset", 32'(WE), 32'(1));
        #2 RST_ = 1'b0;
        #1;
        chk("mid reset WE", 32'(WE), 32'(0));
        chk("mid reset WADDR", 32'(WADDR), 32'(0));
        chk("mid reset BUSY", 32'(BUSY), 32'(0));
        chk("mid reset OVF", 32'(OVF), 32'(0));
        clear();
        tick();
        RST_ = 1'b1;
        send(8'h00);
        send(8'h41);
        repeat (12) tick();
        chk("stray writes", 32'(cap_addr.size()), 32'(0));
        chk("stray BUSY", 32'(BUSY), 32'(0));

        // Three back-to-back data bytes: third is dropped, FSM waits for another.
        send_hdr(8'h00, 8'h00, 8'h00, 8'h00, 8'h03);
        send(8'hAA);
        n = rx_cyc;
        send(8'h55);
        send(8'h0F);
        repeat (20) tick();
        chk("ovf OVF", 32'(OVF), 32'(1));
        chk("ovf BUSY", 32'(BUSY), 32'(1));
        a = 0;
        push_byte(8'hAA, a);
        push_byte(8'h55, a);
        chk_stream("ovf", n + 1);
        send(8'h3C);
        n = rx_cyc;
        wait_idle("ovf tail");
        a = 16;
        push_byte(8'h3C, a);
        chk_stream("ovf tail", n + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
